upe_div32by16uu: RTL and testbench

- Sequential unsigned divider, the inverse of the team's 16x16 unsigned MAC-based multiplier: Quot = Num / Den, Rem = Num % Den.
- Num is the full 32-bit product width; Den, Quot and Rem are 16 bits.
- Radix-2 restoring algorithm, one quotient bit per clock, in fabric logic; SB_MAC16 is not used.
- Used in the uncertainty-propagation datapath to divide accumulated products back down to 16-bit operands.

---
 rtl/upe_pkg.sv | 17 +
 rtl/upe_div_step.sv | 25 ++
 rtl/upe_div32by16uu.sv | 146 ++++++++++++++
 tb/tb_upe_div32by16uu.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/upe_pkg.sv
// Shared definitions for the uncertainty-propagation divider: state encoding,
// default widths and the quotient saturation value.
package upe_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int CNT_W_DEF = 5;

    // Sliced down to WIDTH bits by users; wide enough for any sensible WIDTH.
    localparam logic [63:0] QUOT_SAT = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/upe_div_step.sv
// One radix-2 restoring division step: shift the next dividend bit into the
// partial remainder, subtract the divisor when it fits, emit one quotient bit.
module upe_div_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] r,
    input  logic             din,
    input  logic [WIDTH-1:0] den,
    output logic [WIDTH-1:0] r_next,
    output logic             q_bit
);

    logic [WIDTH:0] t;
    logic [WIDTH:0] diff;

    always_comb begin
        t    = {r, din};
        diff = t - {1'b0, den};
        // With r < den, t < 2*den, so a non-negative difference never sets the
        // top bit and a negative one always does: it doubles as the borrow.
        q_bit  = ~diff[WIDTH];
        r_next = q_bit ? diff[WIDTH-1:0] : t[WIDTH-1:0];
    end

endmodule

// File: rtl/upe_div32by16uu.sv
// Sequential 2W-by-W unsigned restoring divider, one quotient bit per clock,
// with divide-by-zero and quotient-overflow detection up front.
module upe_div32by16uu
    import upe_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               Start,
    input  logic [2*WIDTH-1:0] Num,
    input  logic [WIDTH-1:0]   Den,
    output logic               Busy,
    output logic               Done,
    output logic [WIDTH-1:0]   Quot,
    output logic [WIDTH-1:0]   Rem,
    output logic               DivZero,
    output logic               Ovf
);

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] SAT       = QUOT_SAT[WIDTH-1:0];

    state_e           state_q, state_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] den_q, den_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dz_q, dz_d;
    logic             ovf_q, ovf_d;
    logic             err_pend_q, err_pend_d;

    logic [WIDTH-1:0] step_r_next;
    logic             step_q_bit;
    logic [WIDTH-1:0] num_hi;
    logic [WIDTH-1:0] num_lo;

    assign num_hi = Num[2*WIDTH-1:WIDTH];
    assign num_lo = Num[WIDTH-1:0];

    upe_div_step #(.WIDTH(WIDTH)) u_step (
        .r      (r_q),
        .din    (q_q[WIDTH-1]),
        .den    (den_q),
        .r_next (step_r_next),
        .q_bit  (step_q_bit)
    );

    always_comb begin
        // NOTE: every signal gets its hold value first so no path through the
        // case below can leave one unassigned and infer a latch.
        state_d    = state_q;
        r_d        = r_q;
        q_d        = q_q;
        den_d      = den_q;
        cnt_d      = cnt_q;
        quot_d     = quot_q;
        rem_d      = rem_q;
        dz_d       = dz_q;
        ovf_d      = ovf_q;
        err_pend_d = err_pend_q;

        case (state_q)
            ST_RUN: begin
                r_d   = step_r_next;
                q_d   = {q_q[WIDTH-2:0], step_q_bit};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_STEP) begin
                    state_d = ST_DONE;
                    quot_d  = {q_q[WIDTH-2:0], step_q_bit};
                    rem_d   = step_r_next;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                if (err_pend_q) begin
                    // Error result was decided at accept; publish it a cycle later.
                    state_d    = ST_DONE;
                    quot_d     = SAT;
                    rem_d      = r_q;
                    err_pend_d = 1'b0;
                end else if (Start) begin
                    den_d = Den;
                    cnt_d = '0;
                    if (Den == '0) begin
                        dz_d       = 1'b1;
                        ovf_d      = 1'b0;
                        r_d        = num_lo;
                        err_pend_d = 1'b1;
                    end else if (num_hi >= Den) begin
                        dz_d       = 1'b0;
                        ovf_d      = 1'b1;
                        r_d        = '0;
                        err_pend_d = 1'b1;
                    end else begin
                        dz_d    = 1'b0;
                        ovf_d   = 1'b0;
                        r_d     = num_hi;
                        q_d     = num_lo;
                        state_d = ST_RUN;
                    end
                end
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // its _d value from before the edge, independent of statement order.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            r_q        <= '0;
            q_q        <= '0;
            den_q      <= '0;
            cnt_q      <= '0;
            quot_q     <= '0;
            rem_q      <= '0;
            dz_q       <= 1'b0;
            ovf_q      <= 1'b0;
            err_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            r_q        <= r_d;
            q_q        <= q_d;
            den_q      <= den_d;
            cnt_q      <= cnt_d;
            quot_q     <= quot_d;
            rem_q      <= rem_d;
            dz_q       <= dz_d;
            ovf_q      <= ovf_d;
            err_pend_q <= err_pend_d;
        end
    end

    assign Busy    = (state_q == ST_RUN);
    assign Done    = (state_q == ST_DONE);
    assign Quot    = quot_q;
    assign Rem     = rem_q;
    assign DivZero = dz_q;
    assign Ovf     = ovf_q;

endmodule

// File: tb/tb_upe_div32by16uu.sv
// Scoreboard bench for upe_div32by16uu: the driver pushes expected results from
// a plain-arithmetic model, the monitor pops and compares on every Done pulse.
module tb_upe_div32by16uu;

    localparam int W = 16;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          Start = 1'b0;
    logic [2*W-1:0] Num = '0;
    logic [W-1:0]  Den = '0;
    logic          Busy, Done, DivZero, Ovf;
    logic [W-1:0]  Quot, Rem;

    typedef struct {
        logic [W-1:0] quot;
        logic [W-1:0] rem;
        logic         dz;
        logic         ovf;
        int           lat;
        int           acc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    logic [W-1:0] hold_quot = '0;
    logic [W-1:0] hold_rem  = '0;
    logic         hold_dz   = 1'b0;
    logic         hold_ovf  = 1'b0;

    upe_div32by16uu dut (
        .CLK     (CLK),
        .RST     (RST),
        .Start   (Start),
        .Num     (Num),
        .Den     (Den),
        .Busy    (Busy),
        .Done    (Done),
        .Quot    (Quot),
        .Rem     (Rem),
        .DivZero (DivZero),
        .Ovf     (Ovf)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: real division, with overflow defined as "quotient wider than W bits".
    function automatic exp_t model(input logic [2*W-1:0] n, input logic [W-1:0] d);
        exp_t        e;
        logic [31:0] q32;
        logic [31:0] r32;
        e.acc = 0;
        if (d == '0) begin
            e.quot = '1;
            e.rem  = n[W-1:0];
            e.dz   = 1'b1;
            e.ovf  = 1'b0;
            e.lat  = 1;
        end else begin
            q32 = n / {16'd0, d};
            r32 = n % {16'd0, d};
            if (q32 > 32'h0000_FFFF) begin
                e.quot = '1;
                e.rem  = '0;
                e.dz   = 1'b0;
                e.ovf  = 1'b1;
                e.lat  = 1;
            end else begin
                e.quot = q32[W-1:0];
                e.rem  = r32[W-1:0];
                e.dz   = 1'b0;
                e.ovf  = 1'b0;
                e.lat  = W;
            end
        end
        return e;
    endfunction

    // Call only when the DUT can accept; returns #1 after the accept edge.
    task automatic start_op(input logic [2*W-1:0] n, input logic [W-1:0] d);
        exp_t e;
        e     = model(n, d);
        Num   = n;
        Den   = d;
        Start = 1'b1;
        @(posedge CLK);
        #1;
        Start    = 1'b0;
        e.acc    = cyc;
        hold_dz  = e.dz;
        hold_ovf = e.ovf;
        sb.push_back(e);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 40; i++) begin
            if (sb.size() == 0) break;
            @(negedge CLK);
            #1;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL done_timeout pending=%0d required=0", sb.size());
            sb.delete();
        end
    endtask

    always @(negedge CLK) begin
        if (RST) begin
            hold_quot = '0;
            hold_rem  = '0;
            hold_dz   = 1'b0;
            hold_ovf  = 1'b0;
        end else if (Done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_done actual=1 required=0 (t=%0t)", $time);
            end else begin
                mon_e = sb.pop_front();
                check("quot", Quot, mon_e.quot);
                check("rem", Rem, mon_e.rem);
                check("divzero", DivZero, mon_e.dz);
                check("ovf", Ovf, mon_e.ovf);
                check("latency", cyc - mon_e.acc, mon_e.lat);
                check("busy_at_done", Busy, 0);
                hold_quot = mon_e.quot;
                hold_rem  = mon_e.rem;
            end
        end else begin
            check("hold_quot", Quot, hold_quot);
            check("hold_rem", Rem, hold_rem);
            check("hold_divzero", DivZero, hold_dz);
            check("hold_ovf", Ovf, hold_ovf);
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0]   d;
        logic [W-1:0]   hi;
        logic [W-1:0]   lo;
        logic [2*W-1:0] n;
        int             mode;

        repeat (3) @(negedge CLK);
        check("rst_busy", Busy, 0);
        check("rst_done", Done, 0);
        check("rst_quot", Quot, 0);
        check("rst_rem", Rem, 0);
        check("rst_divzero", DivZero, 0);
        check("rst_ovf", Ovf, 0);
        #1;
        RST = 1'b0;
        @(negedge CLK);
        #1;

        // Basic division: Busy for exactly W cycles, Done on the W-th edge.
        start_op(32'd1000, 16'd7);
        for (int i = 0; i < W; i++) begin
            check("t1_busy", Busy, 1);
            @(posedge CLK);
            #1;
        end
        check("t1_busy_end", Busy, 0);
        check("t1_done", Done, 1);
        wait_done();

        // Largest in-range quotients.
        start_op(32'h0000_FFFF, 16'h0001);
        wait_done();
        start_op(32'hFFFE_0001, 16'hFFFF);
        wait_done();

        // Error paths never raise Busy.
        start_op(32'h1234_5678, 16'd0);
        check("t3_dz_busy0", Busy, 0);
        @(posedge CLK);
        #1;
        check("t3_dz_busy1", Busy, 0);
        check("t3_dz_done", Done, 1);
        wait_done();
        start_op(32'h0002_0000, 16'd2);
        wait_done();

        // Start pulses during RUN are ignored; Start in the DONE cycle is taken.
        start_op(32'd1000, 16'd7);
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK);
            #1;
            Num   = $urandom;
            Den   = 16'($urandom_range(0, 3));
            Start = 1'b1;
            @(posedge CLK);
            #1;
            Start = 1'b0;
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (Done) break;
        end
        check("t4_first_done", Done, 1);
        #1;
        start_op(32'd100, 16'd10);
        wait_done();

        // Asynchronous reset mid-operation aborts without a Done.
        start_op(32'd1000, 16'd7);
        repeat (8) @(posedge CLK);
        #2;
        RST = 1'b1;
        #1;
        check("t5_busy", Busy, 0);
        check("t5_done", Done, 0);
        check("t5_quot", Quot, 0);
        check("t5_rem", Rem, 0);
        check("t5_divzero", DivZero, 0);
        check("t5_ovf", Ovf, 0);
        sb.delete();
        @(negedge CLK);
        #1;
        RST = 1'b0;
        repeat (20) @(negedge CLK);
        #1;
        start_op(32'd50, 16'd5);
        wait_done();

        // Randomised operations, mixing back-to-back and idle-gap starts.
        for (int k = 0; k < 2500; k++) begin
            repeat ($urandom_range(0, 2)) @(negedge CLK);
            #1;
            mode = int'($urandom_range(0, 15));
            d    = 16'($urandom);
            lo   = 16'($urandom);
            if (mode == 0) begin
                d = '0;
                n = $urandom;
            end else if (mode == 1) begin
                n = $urandom;
            end else begin
                if (mode == 2) d = 16'($urandom_range(1, 3));
                if (d == '0) d = 16'd1;
                if (mode == 3) hi = d - 16'd1;
                else           hi = 16'($urandom_range(0, 32'(d) - 1));
                n = {hi, lo};
            end
            start_op(n, d);
            wait_done();
        end

        repeat (3) @(negedge CLK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
